// File: rtl/lsu_ctrl.sv
// lsu_ctrl: executes the memory half of a decoded micro command. One command
// at a time is accepted, turned into a single word-aligned data-memory
// request, and completed with a one-cycle done pulse carrying extended load
// data or an error flag.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_mren,
    input  logic [1:0]  i_mwen,
    input  logic        i_load_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    output logic        o_mem_req_wen,
    output logic [31:0] o_mem_req_wdata,
    output logic [3:0]  o_mem_req_wmask,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_rdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Last WAIT-cycle count value; reaching it without a response aborts.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_mren;
    logic [1:0]  r_mwen;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;

    logic [1:0]  w_size;
    logic        w_both;
    logic        w_misalign;
    logic        w_cmd_err;
    logic        w_cmd_short;
    logic        w_timeout;
    logic [1:0]  w_off;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;

    // Classify the presented command so illegal, misaligned and no-op
    // commands can complete without touching memory.
    always_comb begin
        w_size      = i_mren | i_mwen;
        w_both      = (i_mren != 2'b00) && (i_mwen != 2'b00);
        w_misalign  = ((w_size == 2'b10) && i_addr[0]) ||
                      ((w_size == 2'b11) && (i_addr[1:0] != 2'b00));
        w_cmd_err   = w_both || w_misalign;
        w_cmd_short = w_cmd_err || (w_size == 2'b00);
    end

    // Store lane replication and byte enables, built from the latched command
    // so the request stays stable under backpressure.
    always_comb begin
        w_off     = r_addr[1:0];
        w_timeout = (r_cnt >= TO_LAST);
        w_wmask   = 4'b0000;
        w_wdata   = r_wdata;
        case (r_mwen)
            2'b01: begin
                w_wmask = 4'b0001 << w_off;
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b10: begin
                w_wmask = 4'b0011 << w_off;
                w_wdata = {2{r_wdata[15:0]}};
            end
            2'b11: begin
                w_wmask = 4'b1111;
                w_wdata = r_wdata;
            end
            default: begin
                w_wmask = 4'b0000;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension of the response word.
    always_comb begin
        w_shift = i_mem_resp_rdata >> {w_off, 3'b000};
        w_load  = 32'd0;
        case (r_mren)
            2'b01:   w_load = r_unsigned ? {24'd0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b10:   w_load = r_unsigned ? {16'd0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
            2'b11:   w_load = i_mem_resp_rdata;
            default: w_load = 32'd0;
        endcase
    end

    // State register; reset aborts any in-flight request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_next = w_cmd_short ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_resp_valid || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        o_cmd_ready     = (r_state == S_IDLE);
        o_mem_req_valid = (r_state == S_REQ);
    end

    // Command latch, timeout counter and registered completion outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mren     <= 2'b00;
            r_mwen     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_cnt      <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_mren     <= i_mren;
                        r_mwen     <= i_mwen;
                        r_unsigned <= i_load_unsigned;
                        r_addr     <= i_addr;
                        r_wdata    <= i_wdata;
                        if (w_cmd_short) begin
                            r_done  <= 1'b1;
                            r_err   <= w_cmd_err;
                            r_rdata <= 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        r_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (i_mem_resp_valid) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_mem_req_addr  = {r_addr[31:2], 2'b00};
    assign o_mem_req_wen   = (r_mwen != 2'b00);
    assign o_mem_req_wdata = w_wdata;
    assign o_mem_req_wmask = w_wmask;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_rdata         = r_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors for the load/store control unit with
// hand-computed expected values. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  mren;
    logic [1:0]  mwen;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int vectors;
    int miscompares;

    lsu_ctrl #(.TIMEOUT_CYCLES(255)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_mren           (mren),
        .i_mwen           (mwen),
        .i_load_unsigned  (load_unsigned),
        .i_addr           (addr),
        .i_wdata          (wdata),
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_req_addr   (mem_req_addr),
        .o_mem_req_wen    (mem_req_wen),
        .o_mem_req_wdata  (mem_req_wdata),
        .o_mem_req_wmask  (mem_req_wmask),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_resp_rdata (mem_resp_rdata),
        .o_done           (done),
        .o_rdata          (rdata),
        .o_err            (err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every vector.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one command for a single cycle (cycle 0); returns at the
    // falling edge of cycle 1.
    task automatic applyStimulus(input logic [1:0] mr, input logic [1:0] mw,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] wd);
        @(negedge clk);
        checkOutput("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid     = 1'b1;
        mren          = mr;
        mwen          = mw;
        load_unsigned = uns;
        addr          = a;
        wdata         = wd;
        @(negedge clk);
        cmd_valid     = 1'b0;
        mren          = 2'b00;
        mwen          = 2'b00;
        load_unsigned = 1'b0;
        addr          = 32'd0;
        wdata         = 32'd0;
    endtask

    // From cycle 1 (REQ): ready at cycle 1, response at cycle 2, then waits
    // for done and reports the cycle it appeared at.
    task automatic serviceRequest(input logic [31:0] resp, output int lat);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Directed test sequence.
    initial begin
        int lat;
        logic [31:0] holdAddr;
        logic [31:0] holdWdata;
        logic [3:0]  holdMask;

        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        mren           = 2'b00;
        mwen           = 2'b00;
        load_unsigned  = 1'b0;
        addr           = 32'd0;
        wdata          = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;

        #1;
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rst_req_wen", {31'd0, mem_req_wen}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_req_addr", mem_req_addr, 32'd0);
        checkOutput("rst_req_wdata", mem_req_wdata, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_wmask", {28'd0, mem_req_wmask}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] load word");
        applyStimulus(2'b11, 2'b00, 1'b0, 32'h8000_0004, 32'd0);
        checkOutput("lw_req_valid", {31'd0, mem_req_valid}, 32'd1);
        checkOutput("lw_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("lw_req_addr", mem_req_addr, 32'h8000_0004);
        checkOutput("lw_req_wen", {31'd0, mem_req_wen}, 32'd0);
        checkOutput("lw_wmask", {28'd0, mem_req_wmask}, 32'd0);
        serviceRequest(32'hDEAD_BEEF, lat);
        checkOutput("lw_latency", lat, 32'd3);
        checkOutput("lw_rdata", rdata, 32'hDEAD_BEEF);
        checkOutput("lw_err", {31'd0, err}, 32'd0);
        checkOutput("lw_ready_in_done", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        checkOutput("lw_done_one_cycle", {31'd0, done}, 32'd0);

        $display("[TB] load byte signed/unsigned");
        applyStimulus(2'b01, 2'b00, 1'b0, 32'h8000_0003, 32'd0);
        checkOutput("lb_req_addr", mem_req_addr, 32'h8000_0000);
        serviceRequest(32'h8500_0000, lat);
        checkOutput("lb_latency", lat, 32'd3);
        checkOutput("lb_rdata", rdata, 32'hFFFF_FF85);
        applyStimulus(2'b01, 2'b00, 1'b1, 32'h8000_0003, 32'd0);
        serviceRequest(32'h8500_0000, lat);
        checkOutput("lbu_rdata", rdata, 32'h0000_0085);

        $display("[TB] load half signed at offset 2");
        applyStimulus(2'b10, 2'b00, 1'b0, 32'h8000_0012, 32'd0);
        serviceRequest(32'h8001_7777, lat);
        checkOutput("lh_rdata", rdata, 32'hFFFF_8001);

        $display("[TB] store half, response in handshake cycle ignored");
        applyStimulus(2'b00, 2'b10, 1'b0, 32'h8000_0002, 32'h1234_ABCD);
        checkOutput("sh_req_valid", {31'd0, mem_req_valid}, 32'd1);
        checkOutput("sh_req_wen", {31'd0, mem_req_wen}, 32'd1);
        checkOutput("sh_req_wdata", mem_req_wdata, 32'hABCD_ABCD);
        checkOutput("sh_wmask", {28'd0, mem_req_wmask}, 32'h0000_000C);
        checkOutput("sh_req_addr", mem_req_addr, 32'h8000_0000);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        checkOutput("sh_early_resp_ignored", {31'd0, done}, 32'd0);
        checkOutput("sh_in_wait", {31'd0, mem_req_valid}, 32'd0);
        @(negedge clk);
        checkOutput("sh_still_waiting", {31'd0, done}, 32'd0);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("sh_done", {31'd0, done}, 32'd1);
        checkOutput("sh_err", {31'd0, err}, 32'd0);
        checkOutput("sh_rdata", rdata, 32'd0);

        $display("[TB] store byte at offset 1");
        applyStimulus(2'b00, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_00A5);
        checkOutput("sb_req_wdata", mem_req_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_wmask", {28'd0, mem_req_wmask}, 32'h0000_0002);
        serviceRequest(32'd0, lat);
        checkOutput("sb_latency", lat, 32'd3);

        $display("[TB] misaligned, illegal, no-op commands");
        applyStimulus(2'b11, 2'b00, 1'b0, 32'h8000_0002, 32'd0);
        checkOutput("mis_no_req", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("mis_done", {31'd0, done}, 32'd1);
        checkOutput("mis_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        checkOutput("mis_done_clear", {31'd0, done}, 32'd0);
        applyStimulus(2'b10, 2'b00, 1'b0, 32'h8000_0001, 32'd0);
        checkOutput("mish_done", {31'd0, done}, 32'd1);
        checkOutput("mish_err", {31'd0, err}, 32'd1);
        applyStimulus(2'b01, 2'b01, 1'b0, 32'h8000_0000, 32'd0);
        checkOutput("ill_no_req", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("ill_done", {31'd0, done}, 32'd1);
        checkOutput("ill_err", {31'd0, err}, 32'd1);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'd0);
        checkOutput("nop_no_req", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("nop_done", {31'd0, done}, 32'd1);
        checkOutput("nop_err", {31'd0, err}, 32'd0);
        checkOutput("nop_rdata", rdata, 32'd0);

        $display("[TB] backpressure and timeout");
        applyStimulus(2'b00, 2'b11, 1'b0, 32'h8000_0010, 32'hCAFE_F00D);
        holdAddr  = mem_req_addr;
        holdWdata = mem_req_wdata;
        holdMask  = mem_req_wmask;
        checkOutput("to_req_addr", holdAddr, 32'h8000_0010);
        checkOutput("to_req_wdata", holdWdata, 32'hCAFE_F00D);
        checkOutput("to_wmask", {28'd0, holdMask}, 32'h0000_000F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
            checkOutput("bp_req_addr", mem_req_addr, holdAddr);
            checkOutput("bp_req_wdata", mem_req_wdata, holdWdata);
            checkOutput("bp_wmask", {28'd0, mem_req_wmask}, {28'd0, holdMask});
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        lat = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("to_latency", lat, 32'd255);
        checkOutput("to_err", {31'd0, err}, 32'd1);

        $display("[TB] reset during WAIT");
        applyStimulus(2'b11, 2'b00, 1'b0, 32'h8000_0020, 32'd0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rstw_req_valid", {31'd0, mem_req_valid}, 32'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rstw_no_done", {31'd0, done}, 32'd0);
            checkOutput("rstw_idle", {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
